// File: rtl/mix_columns_stream.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_stream
// Brief    : Pipelined AES/Rijndael MixColumns / InvMixColumns over NB columns
//            with valid/ready handshake. MIX_COLUMNS_BYPASS_EN adds bypass_in.
// Revision : 1.0
// ============================================================================
module mix_columns_stream #(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1,
    parameter int MODE_PIPE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             decrypt_in,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic             bypass_in,
`endif
    input  logic [32*NB-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [32*NB-1:0] data_out
);
    localparam int c_dw = 32 * NB;

    function automatic logic [7:0] f_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [c_dw-1:0] f_xt_word(input logic [c_dw-1:0] v);
        logic [c_dw-1:0] r;
        r = '0;
        for (int k = 0; k < 4 * NB; k++) r[8*k +: 8] = f_xt(v[8*k +: 8]);
        return r;
    endfunction

    // k is the coefficient index (column offset of the source byte vs. the row)
    function automatic logic [7:0] f_term(input logic [7:0] a, input logic [7:0] x2,
                                          input logic [7:0] x4, input logic [7:0] x8,
                                          input logic dec, input int k);
        logic [7:0] t;
        if (dec) begin
            case (k)
                0:       t = x8 ^ x4 ^ x2;
                1:       t = x8 ^ x2 ^ a;
                2:       t = x8 ^ x4 ^ a;
                default: t = x8 ^ a;
            endcase
        end else begin
            case (k)
                0:       t = x2;
                1:       t = x2 ^ a;
                default: t = a;
            endcase
        end
        return t;
    endfunction

    function automatic logic [c_dw-1:0] f_mix_word(input logic [c_dw-1:0] a, input logic [c_dw-1:0] x2,
                                                   input logic [c_dw-1:0] x4, input logic [c_dw-1:0] x8,
                                                   input logic dec);
        logic [c_dw-1:0] r;
        logic [7:0]      acc;
        int              p;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    p = c_dw - 8 - 32*c - 8*j;
                    acc ^= f_term(a[p +: 8], x2[p +: 8], x4[p +: 8], x8[p +: 8], dec, (j - i + 4) % 4);
                end
                r[c_dw - 8 - 32*c - 8*i +: 8] = acc;
            end
        end
        return r;
    endfunction

    logic [c_dw-1:0] w_x2, w_x4, w_x8;
    logic            w_bypass;

    assign w_x2 = f_xt_word(data_in);
    assign w_x4 = f_xt_word(w_x2);
    assign w_x8 = f_xt_word(w_x4);
`ifdef MIX_COLUMNS_BYPASS_EN
    assign w_bypass = bypass_in;
`else
    assign w_bypass = 1'b0;
`endif

    if (PIPE_STAGES == 1) begin : g_one_stage
        logic            r_valid;
        logic [c_dw-1:0] r_data;
        logic            w_load;
        logic            w_unused_cfg;

        // Single stage: the port mode is already the final-stage mode.
        assign w_unused_cfg = (MODE_PIPE != 0);
        assign w_load       = !r_valid || ready_out;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_load) begin
                r_valid <= valid_in;
                if (valid_in)
                    r_data <= w_bypass ? data_in : f_mix_word(data_in, w_x2, w_x4, w_x8, decrypt_in);
            end
        end

        assign ready_in  = w_load;
        assign valid_out = r_valid;
        assign data_out  = r_data;
    end else begin : g_two_stage
        logic            r_v1, r_v2, r_m1, r_b1;
        logic [c_dw-1:0] r_a, r_x2, r_x4, r_x8, r_d2;
        logic            w_load1, w_load2, w_mode2;

        assign w_load2 = !r_v2 || ready_out;
        assign w_load1 = !r_v1 || w_load2;
        assign w_mode2 = (MODE_PIPE != 0) ? r_m1 : decrypt_in;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v1 <= 1'b0;
                r_m1 <= 1'b0;
                r_b1 <= 1'b0;
                r_a  <= '0;
                r_x2 <= '0;
                r_x4 <= '0;
                r_x8 <= '0;
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                if (w_load1) begin
                    r_v1 <= valid_in;
                    if (valid_in) begin
                        r_m1 <= decrypt_in;
                        r_b1 <= w_bypass;
                        r_a  <= data_in;
                        r_x2 <= w_x2;
                        r_x4 <= w_x4;
                        r_x8 <= w_x8;
                    end
                end
                if (w_load2) begin
                    r_v2 <= r_v1;
                    if (r_v1)
                        r_d2 <= r_b1 ? r_a : f_mix_word(r_a, r_x2, r_x4, r_x8, w_mode2);
                end
            end
        end

        assign ready_in  = w_load1;
        assign valid_out = r_v2;
        assign data_out  = r_d2;
    end
endmodule
`default_nettype wire

// File: tb/tb_mix_columns_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_stream
// Brief    : Directed-vector bench for mix_columns_stream (NB=4 two-stage and
//            NB=8 single-stage instances).
// Revision : 1.0
// ============================================================================
module tb_mix_columns_stream;
    localparam int PS1 = 2;
    localparam logic [127:0] C_COLS    = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] C_COLS_MC = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] C_FIPS    = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] C_FIPS_MC = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in, ready_in, decrypt_in, valid_out, ready_out;
    logic [127:0] data_in, data_out;
    logic         n8_valid_in, n8_ready_in, n8_decrypt_in, n8_valid_out, n8_ready_out;
    logic [255:0] n8_data_in, n8_data_out;
`ifdef MIX_COLUMNS_BYPASS_EN
    logic         bypass_in;
`endif
    int total = 0;
    int bad   = 0;

    logic [127:0] s_in[8];
    logic [127:0] s_exp[8];
    logic         s_dec[8];

    always #5 clk = ~clk;

    mix_columns_stream #(.NB(4), .PIPE_STAGES(PS1), .MODE_PIPE(1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .decrypt_in(decrypt_in),
`ifdef MIX_COLUMNS_BYPASS_EN
        .bypass_in(bypass_in),
`endif
        .data_in(data_in), .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out)
    );

    mix_columns_stream #(.NB(8), .PIPE_STAGES(1), .MODE_PIPE(0)) dut8 (
        .clk(clk), .reset(reset), .valid_in(n8_valid_in), .ready_in(n8_ready_in),
        .decrypt_in(n8_decrypt_in),
`ifdef MIX_COLUMNS_BYPASS_EN
        .bypass_in(1'b0),
`endif
        .data_in(n8_data_in), .valid_out(n8_valid_out), .ready_out(n8_ready_out), .data_out(n8_data_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [255:0] model8(input logic [255:0] d, input logic dec);
        logic [255:0] r;
        logic [7:0]   a[4];
        logic [7:0]   acc, cf;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 4; j++) a[j] = d[255 - 32*c - 8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    case ((j - i + 4) % 4)
                        0:       cf = dec ? 8'h0e : 8'h02;
                        1:       cf = dec ? 8'h0b : 8'h03;
                        2:       cf = dec ? 8'h0d : 8'h01;
                        default: cf = dec ? 8'h09 : 8'h01;
                    endcase
                    acc ^= gmul(cf, a[j]);
                end
                r[255 - 32*c - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic run_one(input string name, input logic [127:0] d, input logic dec, input logic [127:0] exp);
        int lat;
        @(posedge clk); #1;
        ready_out = 1'b1; valid_in = 1'b1; data_in = d; decrypt_in = dec;
        lat = 0;
        while (!ready_in && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (ready_in !== 1'b1) begin bad++; $display("FAIL %s accept: ready_in=%b want 1", name, ready_in); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat !== PS1) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, PS1); end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL %s data: got %h want %h", name, data_out, exp); end
        @(posedge clk); #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL %s drain: valid_out=%b want 0", name, valid_out); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL reset data_out: got %h want 0", data_out); end
        total++;
        if (ready_in !== 1'b1) begin bad++; $display("FAIL reset ready_in: got %b want 1", ready_in); end
    endtask

    task automatic test_forward;
        run_one("fwd_cols", C_COLS, 1'b0, C_COLS_MC);
        run_one("fwd_fips", C_FIPS, 1'b0, C_FIPS_MC);
    endtask

    task automatic test_inverse;
        run_one("inv_cols", C_COLS_MC, 1'b1, C_COLS);
        run_one("inv_fips", C_FIPS_MC, 1'b1, C_FIPS);
    endtask

    task automatic fill_stream;
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: begin s_in[i] = C_COLS;    s_dec[i] = 1'b0; s_exp[i] = C_COLS_MC; end
                1: begin s_in[i] = C_FIPS_MC; s_dec[i] = 1'b1; s_exp[i] = C_FIPS;    end
                2: begin s_in[i] = C_FIPS;    s_dec[i] = 1'b0; s_exp[i] = C_FIPS_MC; end
                default: begin s_in[i] = C_COLS_MC; s_dec[i] = 1'b1; s_exp[i] = C_COLS; end
            endcase
        end
    endtask

    task automatic run_stream(input string name, input int n, input bit bp);
        int got, cyc;
        bit saw_full, stall;
        logic [127:0] held;
        got = 0; cyc = 0; saw_full = 1'b0; stall = 1'b0; held = '0;
        @(posedge clk); #1;
        fork
            begin : producer
                for (int i = 0; i < n; i++) begin
                    int w;
                    w = 0;
                    valid_in = 1'b1; data_in = s_in[i]; decrypt_in = s_dec[i];
                    @(negedge clk);
                    while (!ready_in && w < 50) begin saw_full = 1'b1; @(negedge clk); w++; end
                    @(posedge clk); #1;
                end
                valid_in = 1'b0;
            end
            begin : consumer
                while (got < n && cyc < 200) begin
                    ready_out = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
                    @(negedge clk);
                    if (stall) begin
                        total++;
                        if (valid_out !== 1'b1 || data_out !== held) begin
                            bad++;
                            $display("FAIL %s stall hold: got v=%b %h want v=1 %h", name, valid_out, data_out, held);
                        end
                    end
                    stall = valid_out && !ready_out;
                    held  = data_out;
                    if (valid_out && ready_out) begin
                        total++;
                        if (data_out !== s_exp[got]) begin
                            bad++;
                            $display("FAIL %s beat %0d: got %h want %h", name, got, data_out, s_exp[got]);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        ready_out = 1'b1;
        total++;
        if (got !== n) begin bad++; $display("FAIL %s count: got %0d want %0d", name, got, n); end
        total++;
        if (saw_full !== bp) begin bad++; $display("FAIL %s ready_in low seen: got %b want %b", name, saw_full, bp); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL %s extra beat: valid_out=%b want 0", name, valid_out); end
    endtask

    task automatic test_back_to_back;
        fill_stream();
        run_stream("b2b_modes", 8, 1'b0);
    endtask

    task automatic test_backpressure;
        fill_stream();
        run_stream("backpressure", 8, 1'b1);
    endtask

    task automatic test_reset_midstream;
        @(posedge clk); #1;
        ready_out = 1'b0; valid_in = 1'b1; data_in = C_COLS; decrypt_in = 1'b0;
        @(posedge clk); #1;
        data_in = C_FIPS;
        @(posedge clk); #1;
        valid_in = 1'b0;
        total++;
        if (valid_out !== 1'b1 || data_out !== C_COLS_MC) begin
            bad++;
            $display("FAIL midreset in-flight: got v=%b %h want v=1 %h", valid_out, data_out, C_COLS_MC);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL midreset valid_out: got %b want 0", valid_out); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL midreset data_out: got %h want 0", data_out); end
        @(posedge clk); #1;
        reset = 1'b0;
        ready_out = 1'b1;
        run_one("after_reset", C_FIPS, 1'b0, C_FIPS_MC);
    endtask

    task automatic test_nb8_random;
        logic [255:0] q_exp[$];
        logic [255:0] want;
        int got, cyc;
        got = 0; cyc = 0;
        @(posedge clk); #1;
        fork
            begin : n8_producer
                for (int i = 0; i < 1000; i++) begin
                    logic [255:0] d;
                    logic         m;
                    int           w;
                    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
                    m = 1'($urandom_range(0, 1));
                    n8_valid_in = 1'b1; n8_data_in = d; n8_decrypt_in = m;
                    q_exp.push_back(model8(d, m));
                    w = 0;
                    @(negedge clk);
                    while (!n8_ready_in && w < 50) begin @(negedge clk); w++; end
                    @(posedge clk); #1;
                end
                n8_valid_in = 1'b0;
            end
            begin : n8_consumer
                while (got < 1000 && cyc < 5000) begin
                    n8_ready_out = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (n8_valid_out && n8_ready_out) begin
                        want = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
                        total++;
                        if (n8_data_out !== want) begin
                            bad++;
                            $display("FAIL nb8 beat %0d: got %h want %h", got, n8_data_out, want);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        n8_ready_out = 1'b1;
        total++;
        if (got !== 1000) begin bad++; $display("FAIL nb8 count: got %0d want 1000", got); end
    endtask

`ifdef MIX_COLUMNS_BYPASS_EN
    task automatic test_bypass;
        bypass_in = 1'b1;
        run_one("bypass", 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h00112233445566778899aabbccddeeff);
        bypass_in = 1'b0;
        run_one("post_bypass", C_COLS, 1'b0, C_COLS_MC);
    endtask
`endif

    initial begin
        reset = 1'b1;
        valid_in = 1'b0; decrypt_in = 1'b0; data_in = '0; ready_out = 1'b1;
        n8_valid_in = 1'b0; n8_decrypt_in = 1'b0; n8_data_in = '0; n8_ready_out = 1'b1;
`ifdef MIX_COLUMNS_BYPASS_EN
        bypass_in = 1'b0;
`endif
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_nb8_random();
`ifdef MIX_COLUMNS_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mix_columns_stream.md
Name: mix_columns_stream

Overview:
- Parametrised, pipelined AES/Rijndael MixColumns engine for the round datapath, placed between ShiftRows and AddRoundKey.
- Processes NB 32-bit columns per beat, so 128/192/256-bit Rijndael blocks are supported.
- A per-beat mode bit selects the forward transform (encrypt) or InvMixColumns (decrypt).
- Uses a valid/ready handshake with full backpressure and a configurable pipeline depth.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4..8; DATA_WIDTH = 32*NB.
- PIPE_STAGES, 1, register stages; legal values 1 or 2.
- MODE_PIPE, 1, when 1, the mode bit travels with the data through the pipeline; when 0, mode is sampled from the port only at the final stage.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  input beat valid
- ready_in  out  1  block can accept a beat this cycle
- decrypt_in  in  1  0 = MixColumns, 1 = InvMixColumns; qualified by valid_in
- data_in  in  32*NB  state; byte k at bits [DATA_WIDTH-1-8k -: 8]; column c = bytes 4c..4c+3, row 0 first
- valid_out  out  1  output beat valid
- ready_out  in  1  downstream accepts the beat
- data_out  out  32*NB  transformed state, same byte order as data_in

Behaviour:
- Reset: valid_out=0, data_out=0, all stage valids 0, ready_in=1 one cycle after reset deasserts. Reset asserted mid-stream discards all in-flight beats with no partial output.
- Transfer rules:
  - A transfer occurs on an edge where valid && ready are both high.
  - Upstream must hold data_in and decrypt_in stable while valid_in=1 && ready_in=0.
  - The block holds data_out and valid_out stable while valid_out=1 && ready_out=0.
- Pipeline control:
  - Stage s loads when it is empty or when stage s+1 loads (last stage: when ready_out=1).
  - ready_in = stage-1 load condition.
  - Throughput is 1 beat/cycle with ready_out held high; zero bubbles.
  - Latency is PIPE_STAGES cycles from accept to valid_out.
- Arithmetic, GF(2^8) with polynomial 0x11B:
  - xt(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
  - Forward, per column a0..a3: r0 = 2a0^3a1^a2^a3, r1 = a0^2a1^3a2^a3, r2 = a0^a1^2a2^3a3, r3 = 3a0^a1^a2^2a3.
  - Inverse coefficients per row: {0E,0B,0D,09}, {09,0E,0B,0D}, {0D,09,0E,0B}, {0B,0D,09,0E}.
  - Inverse is built from x2=xt(a), x4=xt(x2), x8=xt(x4): 09=x8^a, 0B=x8^x2^a, 0D=x8^x4^a, 0E=x8^x4^x2.
- Stage split:
  - PIPE_STAGES=1: full result registered in one stage.
  - PIPE_STAGES=2: stage 1 registers a, x2, x4, x8 for all bytes plus mode; stage 2 registers the final XOR.
- Mode mixing: consecutive beats may alternate decrypt_in. Each beat uses its own mode; with MODE_PIPE=0 the port must be held constant while beats are in flight.
- Full/empty: when all stages are full and ready_out=0, ready_in=0 and no data is overwritten. When ready_out rises, all stages advance in the same cycle.
- Simultaneous events: accept and emit in the same cycle are legal with no bubble. Reset takes priority over all other events.

Optional Feature:
- Macro: MIX_COLUMNS_BYPASS_EN.
- When defined:
  - Adds input port bypass_in (1 bit), qualified like decrypt_in and piped with the beat.
  - A beat with bypass=1 emits data_in unchanged, with the same latency and handshake. This serves the AES final round.
- When undefined: no bypass_in port exists and every beat is transformed.

Test Plan:
- Forward, NB=4: column db 13 53 45 -> 8e 4d a1 bc; f2 0a 22 5c -> 9f dc 58 9d; c6 c6 c6 c6 -> c6 c6 c6 c6; valid_out exactly PIPE_STAGES cycles after accept.
- Inverse: 8e 4d a1 bc -> db 13 53 45. FIPS-197 round-1 state d4bf5d30e0b452aeb84111f11e2798e5 fwd -> 046681e5e0cb199a48f8d37a2806264c, and inv of that output -> original.
- Backpressure: stream 8 beats, ready_out toggled 1,0,0,1 repeating -> output order preserved, no loss or duplication; data_out stable while stalled; ready_in drops when full.
- Alternating decrypt_in 0/1 on back-to-back beats (PIPE_STAGES=2, MODE_PIPE=1) -> each output matches its own mode.
- Reset asserted with 2 beats in flight -> valid_out=0, data_out=0 immediately; the next accepted beat emerges correctly with no residue.
- NB=8 random states vs. software model, 1000 beats -> bit-exact. With MIX_COLUMNS_BYPASS_EN defined: bypass beat 00112233…eeff -> identical output.
